mux_select_arbiter_4: RTL and testbench
=======================================

Name: mux_select_arbiter_4

Overview:
- Round-robin arbiter for 4 requesters.
- Sits directly upstream of the 4-to-1 line multiplexer and drives its 2-bit select S, so exactly one source I[n] reaches Y at a time.
- Registered one-hot grant plus encoded select, with a bounded hold time per grant so no requester starves.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles one channel keeps the grant while others are requesting; legal range 1..256.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
REQ  input  4  per-channel request; a requester holds its bit high for as long as it wants the line.
LOCK  input  1  extend current grant (used only with the optional feature).
S  output  2  select to the downstream mux; the index of the granted channel.
G  output  4  one-hot grant; all zeros when idle.
VALID  output  1  high when a grant is active, i.e. Y from the mux is meaningful.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- All outputs and state are registered.
- Reset (rst_n=0, asynchronous) sets:
  - S=2'b00, G=4'b0000, VALID=0.
  - state=IDLE, priority pointer ptr=0, hold_cnt=0.
- Reset may occur mid-grant. The grant drops immediately, with no completion.
- Winner search: first set REQ bit scanning ptr, ptr+1, ... mod 4 (wrap 3->0).
- State IDLE:
  - If REQ==0: stay in IDLE; S holds its last value; G=0; VALID=0.
  - If REQ!=0: at the next edge, grant the winner c. Then G=1<<c, S=c, VALID=1, hold_cnt=0, go to GRANT.
  - Latency from REQ to G is 1 cycle.
- State GRANT(c), evaluated each edge in this priority order:
  1. REQ[c]=0 (release): ptr<=c+1 mod 4.
     - If other REQ bits are set, grant the winner of a search from c+1 at this same edge. No bubble cycle; hold_cnt=0.
     - Otherwise go to IDLE: G=0, VALID=0, S unchanged.
  2. REQ[c]=1 and hold_cnt==HOLD_MAX-1 and another REQ bit is set (forced rotation): ptr<=c+1, grant the next winner, hold_cnt=0.
  3. Otherwise: keep the grant. hold_cnt increments, saturating at HOLD_MAX-1.
- Saturation case: when c is the only requester, the grant is held indefinitely.
- A new request appearing while hold_cnt is saturated forces rotation at the next edge.
- Simultaneous REQ bits resolve only through the pointer search. At most one G bit is ever set.
- G, S and VALID always change on the same edge and are mutually consistent: VALID = |G, and S = encode(G) when VALID=1.
- hold_cnt width: max(1, clog2(HOLD_MAX)).
- HOLD_MAX=1 means rotation every cycle when there is contention.
- REQ is sampled only at clock edges. No combinational path from REQ to any output.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - While in GRANT(c) with LOCK=1 and REQ[c]=1, forced rotation is suppressed and hold_cnt is frozen.
  - Release via REQ[c]=0 still works regardless of LOCK.
  - LOCK has no effect in IDLE.
  - After LOCK deasserts, normal counting resumes from the frozen value.
- Not defined: the LOCK port exists but is ignored; no LOCK logic is synthesized.

Test Plan:
1. Reset, REQ=0000 for 5 cycles -> S=00, G=0000, VALID=0 throughout; assert rst_n=0 mid-grant -> outputs clear immediately, not waiting for an edge.
2. From reset, REQ=0100 -> one cycle later G=0100, S=10, VALID=1; drop REQ -> next edge G=0000, VALID=0, S stays 10.
3. REQ=1111 held, HOLD_MAX=8 -> grants rotate 0,1,2,3,0, each lasting exactly 8 cycles, with no gap cycles between grants.
4. Grant on ch1, then REQ changes 0010->1001 at the same edge ch1 releases -> next grant is ch3 (search from 2), S=11, with no idle cycle.
5. Only ch2 requests for 20 cycles -> grant held for all 20; raise REQ[0] at cycle 20 -> ch0 is granted at the following edge.
6. MUX_ARB_LOCK_EN defined, REQ=0011, LOCK=1 during ch0 grant for 30 cycles -> ch0 held for 30 cycles; LOCK=0 -> rotates to ch1 after the remaining hold count. Macro undefined, same stimulus -> rotates after 8 cycles.

Source files
------------

// File: rtl/mux_select_arbiter_4.sv
// Round-robin arbiter driving the select of a 4-to-1 mux, with a bounded hold per grant.
// Optional grant extension via LOCK is compiled in when MUX_ARB_LOCK_EN is defined.
module mux_select_arbiter_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] REQ,
    input  logic       LOCK,
    output logic [1:0] S,
    output logic [3:0] G,
    output logic       VALID
);

    localparam int HCW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]     s_q, s_d;
    logic [3:0]     g_q, g_d;
    logic           valid_q, valid_d;

    logic           lock_active;
    logic           do_grant;
    logic [1:0]     search_from;
    logic [1:0]     winner;
    logic [1:0]     cur;
    logic [3:0]     others;

`ifdef MUX_ARB_LOCK_EN
    assign lock_active = LOCK;
`else
    logic unused_lock;
    assign unused_lock = LOCK;
    assign lock_active = 1'b0;
`endif

    // First set bit scanning start, start+1, ... mod 4; scanned backwards so the earliest hit wins.
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) pick = idx;
        end
    endfunction

    assign cur    = s_q;
    assign others = REQ & ~(4'b0001 << cur);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        s_d         = s_q;
        g_d         = g_q;
        valid_d     = valid_q;
        do_grant    = 1'b0;
        search_from = ptr_q;
        winner      = 2'd0;

        case (state_q)
            IDLE: begin
                if (REQ != 4'b0000) do_grant = 1'b1;
            end
            GRANT: begin
                if (!REQ[cur]) begin
                    ptr_d       = cur + 2'd1;
                    search_from = cur + 2'd1;
                    if (REQ != 4'b0000) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        g_d     = 4'b0000;
                        valid_d = 1'b0;
                    end
                end else if (lock_active) begin
                    hold_cnt_d = hold_cnt_q;
                end else if (hold_cnt_q == HOLD_LAST && others != 4'b0000) begin
                    ptr_d       = cur + 2'd1;
                    search_from = cur + 2'd1;
                    do_grant    = 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            winner     = pick(REQ, search_from);
            state_d    = GRANT;
            s_d        = winner;
            g_d        = 4'b0001 << winner;
            valid_d    = 1'b1;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            s_q        <= 2'd0;
            g_q        <= 4'b0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            s_q        <= s_d;
            g_q        <= g_d;
            valid_q    <= valid_d;
        end
    end

    assign S     = s_q;
    assign G     = g_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_mux_select_arbiter_4.sv
// Directed self-checking bench for mux_select_arbiter_4 (HOLD_MAX=8).
// The LOCK step expects extended holding only when MUX_ARB_LOCK_EN is defined.
module tb_mux_select_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] REQ;
    logic       LOCK;
    logic [1:0] S;
    logic [3:0] G;
    logic       VALID;

    int total;
    int bad;

    mux_select_arbiter_4 #(.HOLD_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .REQ   (REQ),
        .LOCK  (LOCK),
        .S     (S),
        .G     (G),
        .VALID (VALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] req, input logic lock);
        REQ  = req;
        LOCK = lock;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] exp_s,
                               input logic [3:0] exp_g, input logic exp_v);
        logic [6:0] observed;
        logic [6:0] expected;
        observed = {S, G, VALID};
        expected = {exp_s, exp_g, exp_v};
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed S/G/V=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkGrant(input string tag, input logic [1:0] ch);
        checkOutput(tag, ch, 4'b0001 << ch, 1'b1);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #2;
        checkOutput("reset_pulse", 2'b00, 4'b0000, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        #3;
        checkOutput("reset_initial", 2'b00, 4'b0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("idle_no_req", 2'b00, 4'b0000, 1'b0);
        end

        // Single request on ch2, then release; S keeps last value
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkGrant("single_ch2", 2'd2);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("release_idle_s_held", 2'b10, 4'b0000, 1'b0);

        // Full contention: 8-cycle grants rotating 0,1,2,3,0 with no gaps
        pulseReset();
        applyStimulus(4'b1111, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 8; j++) begin
                checkGrant("rotate_all", 2'(k % 4));
                tick();
            end
        end
        checkGrant("rotate_after_wrap", 2'd1);

        // Release of ch1 with ch0/ch3 requesting at the same edge: search from ch2 -> ch3
        pulseReset();
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkGrant("grant_ch1", 2'd1);
        applyStimulus(4'b1001, 1'b0);
        tick();
        checkGrant("release_handoff_ch3", 2'd3);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("handoff_then_idle", 2'b11, 4'b0000, 1'b0);

        // Lone requester holds indefinitely; a new request at saturation rotates next edge
        pulseReset();
        applyStimulus(4'b0100, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            checkGrant("lone_hold_ch2", 2'd2);
            tick();
        end
        checkGrant("lone_hold_ch2_end", 2'd2);
        applyStimulus(4'b0101, 1'b0);
        tick();
        checkGrant("saturated_rotate_ch0", 2'd0);

        // LOCK during ch0 grant with ch1 contending
        pulseReset();
        applyStimulus(4'b0011, 1'b1);
        tick();
`ifdef MUX_ARB_LOCK_EN
        for (int i = 0; i < 30; i++) begin
            checkGrant("lock_hold_ch0", 2'd0);
            tick();
        end
        applyStimulus(4'b0011, 1'b0);
`endif
        for (int i = 0; i < 8; i++) begin
            checkGrant("hold_ch0_8", 2'd0);
            tick();
        end
        checkGrant("rotate_to_ch1", 2'd1);

        // Asynchronous reset mid-grant clears outputs between edges
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_mid_grant", 2'b00, 4'b0000, 1'b0);
        tick();
        checkOutput("held_in_reset", 2'b00, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
